aes_pipe_core: RTL and testbench

Parametrised, fully unrolled AES block-cipher pipeline supporting AES-128/192/256 through a key-length parameter. It has valid/ready flow control with a global pipeline stall and a pass-through tag sideband. Decrypt mode is optional and selected per transaction. It sits between the key-expansion unit, which supplies the round-key array, and the mode/stream logic (CTR/ECB wrappers), which consumes the result.

---
 rtl/aes_pkg.sv | 99 +++++++++
 rtl/aes_round_stage.sv | 34 +++
 rtl/aes_pipe_core.sv | 91 +++++++++
 tb/tb_aes_pipe_core.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES constant tables and byte/state transforms shared by the pipeline core and its round stages.
package aes_pkg;
  localparam int NR_MAX = 14;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic int aes_nr(input int key_bits);
    case (key_bits)
      128:     return 10;
      192:     return 12;
      256:     return 14;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = SBOX[s[8*i +: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
    return o;
  endfunction

  // Byte 4c+r is row r of column c; byte 0 sits in the top bits.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  // Circulant column multiply; coef holds the first matrix row, MSB byte first.
  function automatic logic [127:0] mix_generic(input logic [127:0] s, input logic [31:0] coef);
    logic [127:0] o;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(s[127-8*(4*c+k) -: 8], coef[31-8*((k+4-r)%4) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return mix_generic(s, 32'h02030101);
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return mix_generic(s, 32'h0e0b0d09);
  endfunction
endpackage

// File: rtl/aes_round_stage.sv
// One combinational AES round; inverse path exists only when AES_DECRYPT_EN is defined.
module aes_round_stage
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rkey,
`ifdef AES_DECRYPT_EN
  input  logic         dec,
`endif
  input  logic         last,
  output logic [127:0] next_state
);
  logic [127:0] enc;

  always_comb begin
    enc = shift_rows(sub_bytes(state));
    if (!last) enc = mix_columns(enc);
    enc = enc ^ rkey;
  end

`ifdef AES_DECRYPT_EN
  logic [127:0] dcr;

  // Key is added before InvMixColumns: straight inverse cipher, no schedule rework needed.
  always_comb begin
    dcr = inv_sub_bytes(inv_shift_rows(state)) ^ rkey;
    if (!last) dcr = inv_mix_columns(dcr);
  end

  assign next_state = dec ? dcr : enc;
`else
  assign next_state = enc;
`endif
endmodule

// File: rtl/aes_pipe_core.sv
// Fully unrolled AES-128/192/256 pipeline (NR+1 stages) with global stall and tag sideband.
// Define AES_DECRYPT_EN to add per-transaction decrypt (in_dec_i port, inverse round logic).
module aes_pipe_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128,
  parameter int TAG_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_vld_i,
  output logic                   in_rdy_o,
  input  logic [127:0]           in_data_i,
  input  logic [TAG_W-1:0]       in_tag_i,
`ifdef AES_DECRYPT_EN
  input  logic                   in_dec_i,
`endif
  input  logic [NR_MAX:0][127:0] rkey_i,
  output logic                   out_vld_o,
  input  logic                   out_rdy_i,
  output logic [127:0]           out_data_o,
  output logic [TAG_W-1:0]       out_tag_o
);
  localparam int NR = aes_nr(KEY_BITS);

  if (NR == 0) begin : g_bad_key
    $error("aes_pipe_core: KEY_BITS must be 128, 192 or 256");
  end

  logic                      adv;
  logic [NR:0]               vld_pipe;
  logic [NR:0][127:0]        data_pipe;
  logic [NR:0][TAG_W-1:0]    tag_pipe;
  logic [NR-1:0][127:0]      rnd_out;
  logic [127:0]              s0_data;
  logic                      unused_rkey;

  // Keys above NR are intentionally ignored.
  assign unused_rkey = ^rkey_i;

  assign adv      = !vld_pipe[NR] | out_rdy_i;
  assign in_rdy_o = adv;

`ifdef AES_DECRYPT_EN
  logic [NR:0] dec_pipe;
  assign s0_data = in_data_i ^ (in_dec_i ? rkey_i[NR] : rkey_i[0]);
`else
  assign s0_data = in_data_i ^ rkey_i[0];
`endif

  for (genvar r = 1; r <= NR; r++) begin : g_rnd
    logic [127:0] rk;
`ifdef AES_DECRYPT_EN
    assign rk = dec_pipe[r-1] ? rkey_i[NR-r] : rkey_i[r];
`else
    assign rk = rkey_i[r];
`endif
    aes_round_stage u_stage (
      .state      (data_pipe[r-1]),
      .rkey       (rk),
`ifdef AES_DECRYPT_EN
      .dec        (dec_pipe[r-1]),
`endif
      .last       (r == NR),
      .next_state (rnd_out[r-1])
    );
  end

  // Every stage shifts together; invalid stages carry don't-care payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
      tag_pipe  <= '0;
`ifdef AES_DECRYPT_EN
      dec_pipe  <= '0;
`endif
    end else if (adv) begin
      vld_pipe  <= {vld_pipe[NR-1:0], in_vld_i};
      data_pipe <= {rnd_out, s0_data};
      tag_pipe  <= {tag_pipe[NR-1:0], in_tag_i};
`ifdef AES_DECRYPT_EN
      dec_pipe  <= {dec_pipe[NR-1:0], in_dec_i};
`endif
    end
  end

  assign out_vld_o  = vld_pipe[NR];
  assign out_data_o = data_pipe[NR];
  assign out_tag_o  = tag_pipe[NR];
endmodule

// File: tb/tb_aes_pipe_core.sv
// Directed bench for aes_pipe_core: FIPS-197 / SP800-38A vectors on 128/192/256 instances.
module tb_aes_pipe_core;
  typedef logic [14:0][127:0] rk_t;

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KSP  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic [127:0] sp_pt [5] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                              128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710,
                              128'h3243f6a8885a308d313198a2e0370734};
  logic [127:0] sp_ct [5] = '{128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'hf5d3d58503b9699de785895a96fdbaaf,
                              128'h43b1cd7f598ece23881b00e3ed030688, 128'h7b0c785e27e8ad3f8223207104725dd4,
                              128'h3925841d02dc09fbdc118597196a0b32};

  logic clk = 1'b0, rst_n = 1'b0, in_vld = 1'b0, out_rdy = 1'b1;
  logic [127:0] d128 = '0, d192 = '0, d256 = '0;
  logic [7:0]   tag = '0;
  rk_t          rk128, rk192, rk256;
  logic         rdy128, rdy192, rdy256, ov128, ov192, ov256;
  logic [127:0] od128, od192, od256;
  logic [7:0]   ot128, ot192, ot256;
`ifdef AES_DECRYPT_EN
  logic dec = 1'b0;
`endif
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  aes_pipe_core #(.KEY_BITS(128), .TAG_W(8)) u128 (
    .clk(clk), .rst_n(rst_n), .in_vld_i(in_vld), .in_rdy_o(rdy128), .in_data_i(d128), .in_tag_i(tag),
`ifdef AES_DECRYPT_EN
    .in_dec_i(dec),
`endif
    .rkey_i(rk128), .out_vld_o(ov128), .out_rdy_i(out_rdy), .out_data_o(od128), .out_tag_o(ot128));
  aes_pipe_core #(.KEY_BITS(192), .TAG_W(8)) u192 (
    .clk(clk), .rst_n(rst_n), .in_vld_i(in_vld), .in_rdy_o(rdy192), .in_data_i(d192), .in_tag_i(tag),
`ifdef AES_DECRYPT_EN
    .in_dec_i(dec),
`endif
    .rkey_i(rk192), .out_vld_o(ov192), .out_rdy_i(out_rdy), .out_data_o(od192), .out_tag_o(ot192));
  aes_pipe_core #(.KEY_BITS(256), .TAG_W(8)) u256 (
    .clk(clk), .rst_n(rst_n), .in_vld_i(in_vld), .in_rdy_o(rdy256), .in_data_i(d256), .in_tag_i(tag),
`ifdef AES_DECRYPT_EN
    .in_dec_i(dec),
`endif
    .rkey_i(rk256), .out_vld_o(ov256), .out_rdy_i(out_rdy), .out_data_o(od256), .out_tag_o(ot256));

  // Independent GF(2^8) S-box used only to build round keys.
  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] inv, r, s;
    inv = '0;
    for (int y = 1; y < 256; y++) if (x != 0 && tb_gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    r = inv; s = inv;
    for (int k = 0; k < 4; k++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] tb_subw(input logic [31:0] w);
    return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
  endfunction

  function automatic rk_t kx(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rk_t         rk;
    rc = 8'h01;
    rk = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = tb_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) t = tb_subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nk + 6; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_vld = 1'b1; out_rdy = 1'b0;
    repeat (2) tick();
    checks++;
    if ({ov128, od128, ot128, rdy128} !== {1'b0, 128'h0, 8'h0, 1'b1}) begin
      failures++; $display("FAIL reset_outputs got vld=%b data=%h tag=%h rdy=%b want 0/0/0/1", ov128, od128, ot128, rdy128);
    end
    checks++;
    if ({ov192, ov256, rdy192, rdy256} !== 4'b0011) begin
      failures++; $display("FAIL reset_other_keys got %b want 0011", {ov192, ov256, rdy192, rdy256});
    end
    in_vld = 1'b0; rst_n = 1'b1;
    tick();
    checks++;
    if ({ov128, rdy128} !== 2'b01) begin
      failures++; $display("FAIL reset_release got vld=%b rdy=%b want 0/1", ov128, rdy128);
    end
  endtask

  task automatic test_fips();
    do_reset();
    d128 = PT; d192 = PT; d256 = PT; tag = 8'h5a; in_vld = 1'b1;
    tick();
    in_vld = 1'b0; tag = 8'h00;
    for (int k = 1; k <= 15; k++) begin
      if (k == 10 || k == 12 || k == 14) begin
        checks++;
        if ((k == 10 ? ov128 : k == 12 ? ov192 : ov256) !== 1'b0) begin
          failures++; $display("FAIL fips_early_vld k=%0d got 1 want 0", k);
        end
      end
      if (k == 11) begin
        checks++;
        if ({ov128, od128, ot128} !== {1'b1, CT128, 8'h5a}) begin
          failures++; $display("FAIL fips_c1 got vld=%b data=%h tag=%h want 1/%h/5a", ov128, od128, ot128, CT128);
        end
      end
      if (k == 13) begin
        checks++;
        if ({ov192, od192, ot192} !== {1'b1, CT192, 8'h5a}) begin
          failures++; $display("FAIL fips_c2 got vld=%b data=%h tag=%h want 1/%h/5a", ov192, od192, ot192, CT192);
        end
      end
      if (k == 15) begin
        checks++;
        if ({ov256, od256, ot256} !== {1'b1, CT256, 8'h5a}) begin
          failures++; $display("FAIL fips_c3 got vld=%b data=%h tag=%h want 1/%h/5a", ov256, od256, ot256, CT256);
        end
      end
      tick();
    end
  endtask

`ifdef AES_DECRYPT_EN
  task automatic test_decrypt();
    do_reset();
    d128 = CT128; d192 = CT192; d256 = CT256; tag = 8'hd0; dec = 1'b1; in_vld = 1'b1;
    tick();
    in_vld = 1'b0; dec = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 11 || k == 13 || k == 15) begin
        checks++;
        if ((k == 11 ? {ov128, od128} : k == 13 ? {ov192, od192} : {ov256, od256}) !== {1'b1, PT}) begin
          failures++; $display("FAIL decrypt k=%0d got %h want %h", k, k == 11 ? od128 : k == 13 ? od192 : od256, PT);
        end
      end
      tick();
    end
    // Interleaved enc/dec on consecutive cycles.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; dec = i[0]; d128 = i[0] ? CT128 : PT; tag = 8'(i);
      tick();
    end
    in_vld = 1'b0; dec = 1'b0;
    for (int k = 4; k <= 15; k++) begin
      if (k >= 11 && k <= 14) begin
        checks++;
        if ({ov128, od128, ot128} !== {1'b1, ((k - 11) % 2 == 1) ? PT : CT128, 8'(k - 11)}) begin
          failures++; $display("FAIL enc_dec_mix k=%0d got vld=%b data=%h tag=%h", k, ov128, od128, ot128);
        end
      end
      tick();
    end
  endtask
`endif

  task automatic test_back_to_back();
    int first, last, nin, nout;
    do_reset();
    rk128 = kx(KSP, 4);
    first = -1; last = -1; nin = 0; nout = 0;
    for (int cyc = 0; cyc < 300 && nout < 100; cyc++) begin
      in_vld = (nin < 100); d128 = sp_pt[nin % 5]; tag = 8'(nin);
      #1;
      if (ov128) begin
        checks++;
        if (od128 !== sp_ct[nout % 5] || ot128 !== 8'(nout)) begin
          failures++; $display("FAIL b2b_data idx=%0d got %h/%h want %h/%h", nout, od128, ot128, sp_ct[nout % 5], 8'(nout));
        end
        if (first < 0) first = cyc;
        last = cyc;
        nout++;
      end
      if (in_vld && rdy128) nin++;
      tick();
    end
    in_vld = 1'b0;
    checks++;
    if (first !== 11) begin
      failures++; $display("FAIL b2b_latency got %0d want 11", first);
    end
    checks++;
    if (nout !== 100 || last - first !== 99) begin
      failures++; $display("FAIL b2b_throughput got count=%0d span=%0d want 100/99", nout, last - first);
    end
  endtask

  task automatic test_backpressure();
    int nin, nout, extra;
    logic hold, stall;
    logic [127:0] held_d;
    logic [7:0]   held_t;
    do_reset();
    rk128 = kx(KSP, 4);
    nin = 0; nout = 0; hold = 1'b0; stall = 1'b0; held_d = '0; held_t = '0;
    for (int cyc = 0; cyc < 3000 && nout < 32; cyc++) begin
      if (!hold) in_vld = (nin < 32) && ($urandom_range(0, 3) != 0);
      d128 = sp_pt[nin % 5]; tag = 8'(nin);
      out_rdy = ($urandom_range(0, 1) == 1);
      #1;
      if (stall) begin
        checks++;
        if ({ov128, od128, ot128} !== {1'b1, held_d, held_t}) begin
          failures++; $display("FAIL stall_hold got vld=%b data=%h tag=%h want 1/%h/%h", ov128, od128, ot128, held_d, held_t);
        end
      end
      stall = 1'b0;
      if (ov128 && out_rdy) begin
        checks++;
        if (od128 !== sp_ct[nout % 5] || ot128 !== 8'(nout)) begin
          failures++; $display("FAIL bp_data idx=%0d got %h/%h want %h/%h", nout, od128, ot128, sp_ct[nout % 5], 8'(nout));
        end
        nout++;
      end else if (ov128) begin
        stall = 1'b1; held_d = od128; held_t = ot128;
        checks++;
        if (rdy128 !== 1'b0) begin
          failures++; $display("FAIL stall_in_rdy got %b want 0", rdy128);
        end
      end
      hold = in_vld && !rdy128;
      if (in_vld && rdy128) nin++;
      tick();
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    checks++;
    if (nout !== 32) begin
      failures++; $display("FAIL bp_count got %0d want 32", nout);
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (ov128) extra++;
      tick();
    end
    checks++;
    if (extra !== 0) begin
      failures++; $display("FAIL bp_duplicate got %0d extra outputs want 0", extra);
    end
  endtask

  task automatic test_reset_midflight();
    int stale;
    do_reset();
    rk128 = kx(K128, 4);
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_vld = 1'b1; d128 = PT ^ 128'(i); tag = 8'(i + 1);
      tick();
    end
    in_vld = 1'b0;
    repeat (8) tick();
    checks++;
    if ({ov128, rdy128} !== 2'b10) begin
      failures++; $display("FAIL midflight_stalled got vld=%b rdy=%b want 1/0", ov128, rdy128);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ov128, od128, ot128, rdy128} !== {1'b0, 128'h0, 8'h0, 1'b1}) begin
      failures++; $display("FAIL midflight_async got vld=%b data=%h tag=%h rdy=%b want 0/0/0/1", ov128, od128, ot128, rdy128);
    end
    tick();
    rst_n = 1'b1; out_rdy = 1'b1;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ov128) stale++;
    end
    checks++;
    if (stale !== 0) begin
      failures++; $display("FAIL midflight_stale got %0d outputs want 0", stale);
    end
    d128 = PT; tag = 8'h77; in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    repeat (10) tick();
    checks++;
    if ({ov128, od128, ot128} !== {1'b1, CT128, 8'h77}) begin
      failures++; $display("FAIL midflight_cold got vld=%b data=%h tag=%h want 1/%h/77", ov128, od128, ot128, CT128);
    end
  endtask

  initial begin
    rk128 = kx(K128, 4);
    rk192 = kx(K192, 6);
    rk256 = kx(K256, 8);
    test_reset();
    test_fips();
`ifdef AES_DECRYPT_EN
    test_decrypt();
`endif
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
